// File: rtl/seg_display_pkg.sv
// Shared types and active-high 7-segment codes for the scanned display driver.
package seg_display_pkg;

  typedef logic [6:0] seg_t;     // {g,f,e,d,c,b,a}
  typedef logic [3:0] nibble_t;

  localparam seg_t SEG_CODES [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg_scan_display_if.sv
// System-side load/blank controls and board-side display pins of seg_scan_display.
interface seg_scan_display_if #(
  parameter int DIGITS = 4
);
  import seg_display_pkg::*;

  logic                  load;
  logic [4*DIGITS-1:0]   data_in;
  logic [DIGITS-1:0]     blank_mask;
  logic [DIGITS-1:0]     an;
  seg_t                  seg;
  logic                  pending;

  modport master (
    output load, data_in, blank_mask,
    input  an, seg, pending
  );

  modport slave (
    input  load, data_in, blank_mask,
    output an, seg, pending
  );

endinterface

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-high 7-segment decoder.
module seg_hex_decode
  import seg_display_pkg::*;
(
  input  nibble_t nib_i,
  output seg_t    seg_o
);

  assign seg_o = SEG_CODES[nib_i];

endmodule

// File: rtl/seg_scan_display.sv
// Time-multiplexed N-digit 7-segment driver with frame-synchronous double-buffered load.
// Optional macro SEG_LEADING_ZERO_BLANK_EN darkens leading zero digits (digit 0 always shown).
module seg_scan_display
  import seg_display_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic              clk,
  input  logic              rst,
  seg_scan_display_if.slave bus
);

  localparam int CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DATA_W = 4 * DIGITS;

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
  // XOR masks: zero for active-high pins, all ones for active-low pins
  localparam logic [DIGITS-1:0] AN_POL   = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
  localparam seg_t              SEG_POL  = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] disp_q, disp_d;
  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic              pend_q, pend_d;
  logic [DIGITS-1:0] an_q, an_d;
  seg_t              seg_q, seg_d;

  logic              tick;
  logic              frame_end;
  nibble_t           cur_nib;
  seg_t              cur_seg;
  logic [DIGITS-1:0] lz_blank;
  logic              slot_dark;

  assign tick      = (cnt_q == CNT_LAST);
  assign frame_end = tick && (idx_q == IDX_LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (tick) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // A load coinciding with the frame boundary bypasses the shadow entirely
  always_comb begin
    disp_d   = disp_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    if (bus.load) begin
      shadow_d = bus.data_in;
      if (frame_end) begin
        disp_d = bus.data_in;
        pend_d = 1'b0;
      end else begin
        pend_d = 1'b1;
      end
    end else if (frame_end && pend_q) begin
      disp_d = shadow_q;
      pend_d = 1'b0;
    end
  end

`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic zero_run;

  always_comb begin
    lz_blank = '0;
    zero_run = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_run    = zero_run && (disp_q[4*i +: 4] == 4'h0);
      lz_blank[i] = zero_run;
    end
  end
`else
  assign lz_blank = '0;
`endif

  assign cur_nib   = disp_q[4*int'(idx_q) +: 4];
  assign slot_dark = bus.blank_mask[idx_q] | lz_blank[idx_q];

  seg_hex_decode u_decode (
    .nib_i (cur_nib),
    .seg_o (cur_seg)
  );

  always_comb begin
    an_d  = AN_POL;
    seg_d = SEG_POL;
    if (!slot_dark) begin
      an_d  = (DIGITS'(1) << idx_q) ^ AN_POL;
      seg_d = cur_seg ^ SEG_POL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      disp_q   <= '0;
      shadow_q <= '0;
      pend_q   <= 1'b0;
      an_q     <= AN_POL;
      seg_q    <= SEG_POL;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      disp_q   <= disp_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
    end
  end

  assign bus.an      = an_q;
  assign bus.seg     = seg_q;
  assign bus.pending = pend_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Randomized bench for seg_scan_display against a time-indexed behavioural display model.
module tb_seg_scan_display;

  localparam int DIGITS = 4;
  localparam int RD     = 4;
  localparam int FRAME  = RD * DIGITS;

  localparam logic [6:0] CODES [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  seg_scan_display_if #(.DIGITS(DIGITS)) bus ();

  seg_scan_display #(
    .DIGITS      (DIGITS),
    .REFRESH_DIV (RD),
    .ACTIVE_LOW  (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Model: e = clock edges since reset release; digit shown follows from e directly
  int          e;
  logic [15:0] m_disp;
  logic [15:0] m_shadow;
  logic        m_pend;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic bit lz_dark(input logic [15:0] v, input int d);
`ifdef SEG_LEADING_ZERO_BLANK_EN
    return (d > 0) && ((v >> (4 * d)) == 16'h0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_edge();
    int d;
    bit boundary;
    if (rst) begin
      e        = 0;
      m_disp   = '0;
      m_shadow = '0;
      m_pend   = 1'b0;
      exp_an   = 4'hF;
      exp_seg  = 7'h7F;
    end else begin
      d = (e / RD) % DIGITS;
      if (bus.blank_mask[d] || lz_dark(m_disp, d)) begin
        exp_an  = 4'hF;
        exp_seg = 7'h7F;
      end else begin
        exp_an  = ~(4'b0001 << d);
        exp_seg = ~CODES[m_disp[4*d +: 4]];
      end
      boundary = ((e % FRAME) == FRAME - 1);
      if (bus.load) begin
        m_shadow = bus.data_in;
        if (boundary) begin
          m_disp = bus.data_in;
          m_pend = 1'b0;
        end else begin
          m_pend = 1'b1;
        end
      end else if (boundary && m_pend) begin
        m_disp = m_shadow;
        m_pend = 1'b0;
      end
      e++;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_val("an", 32'(bus.an), 32'(exp_an));
    check_val("seg", 32'(bus.seg), 32'(exp_seg));
    check_val("pending", 32'(bus.pending), 32'(m_pend));
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  // Advance until the next edge is in the given digit slot (-1: frame-boundary edge)
  task automatic advance_to(input int slot);
    int guard;
    guard = 0;
    while (((slot < 0) ? ((e % FRAME) != FRAME - 1) : (((e / RD) % DIGITS) != slot))
           && guard < 2 * FRAME) begin
      cycle();
      guard++;
    end
    if (guard >= 2 * FRAME) check_val("advance_timeout", 32'(guard), 32'(0));
  endtask

  initial begin
    rst            = 1'b1;
    bus.load       = 1'b0;
    bus.data_in    = '0;
    bus.blank_mask = '0;

    run(3);
    check_val("rst_an", 32'(bus.an), 32'h0F);
    check_val("rst_seg", 32'(bus.seg), 32'h7F);
    check_val("rst_pending", 32'(bus.pending), 32'h0);

    rst = 1'b0;
    check_val("release_an", 32'(bus.an), 32'h0F);
    cycle();
    check_val("first_an", 32'(bus.an), 32'b1110);
    check_val("first_seg", 32'(bus.seg), 32'b1000000);

    // Load in the first frame, then watch a few full scan periods
    bus.load    = 1'b1;
    bus.data_in = 16'h1234;
    cycle();
    bus.load    = 1'b0;
    check_val("load1_pending", 32'(bus.pending), 32'h1);
    run(3 * FRAME);

    // Mid-frame load during the digit-2 slot
    advance_to(2);
    bus.load    = 1'b1;
    bus.data_in = 16'hABCD;
    cycle();
    bus.load    = 1'b0;
    check_val("midload_pending", 32'(bus.pending), 32'h1);
    run(2 * FRAME);

    // Load exactly on the frame boundary bypasses the shadow
    advance_to(-1);
    bus.load    = 1'b1;
    bus.data_in = 16'h0F0F;
    cycle();
    bus.load    = 1'b0;
    check_val("simul_pending", 32'(bus.pending), 32'h0);
    cycle();
    check_val("simul_d0_seg", 32'(bus.seg), 32'b0001110);
    run(FRAME);

    bus.blank_mask = 4'b1000;
    run(2 * FRAME);
    bus.blank_mask = 4'b0000;

    // Reset during the digit-2 slot
    advance_to(2);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check_val("midrst_an", 32'(bus.an), 32'h0F);
    run(FRAME);

    bus.load    = 1'b1;
    bus.data_in = 16'h0050;
    cycle();
    bus.load    = 1'b0;
    run(3 * FRAME);

    repeat (3000) begin
      bus.load = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 3))
        0:       bus.data_in = 16'($urandom);
        1:       bus.data_in = 16'($urandom) & 16'h00FF;
        2:       bus.data_in = 16'($urandom) & 16'h000F;
        default: bus.data_in = 16'($urandom) & 16'h0F0F;
      endcase
      bus.blank_mask = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
      rst = ($urandom_range(0, 299) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
